// File: rtl/pixelscale_pkg.sv
// -----------------------------------------------------------------------------
// pixelscale_pkg
// Shared constants for the pixel scaling datapath: default operand widths,
// derived product/accumulator widths, the fixed-point 1.0 constant and a
// helper used to size accumulators for a given tap count.
// -----------------------------------------------------------------------------
package pixelscale_pkg;

  localparam int N_DEF         = 16;  // pixel operand width into the multiplier
  localparam int R_DEF         = 8;   // integer bits of the weight
  localparam int PRECISION_DEF = 16;  // fractional bits of the weight
  localparam int TAPS_DEF      = 4;   // bilinear: four products per pixel
  localparam int OUT_W_DEF     = 8;   // output pixel width

  localparam int PROD_W = PRECISION_DEF + N_DEF + R_DEF;
  localparam int ACC_W  = PROD_W + $clog2(TAPS_DEF);

  // Fixed-point 1.0 for a weight with PRECISION_DEF fractional bits.
  localparam longint unsigned ONE_FX = 64'd1 << PRECISION_DEF;

  // Width that holds the sum of `taps` unsigned products without overflow.
  function automatic int acc_width(input int prod_w, input int taps);
    return prod_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/interp_accum_if.sv
// -----------------------------------------------------------------------------
// interp_accum_if
// Product-in / pixel-out stream bundle for interp_accum.
//   in_prod/in_sop/in_valid/in_ready : product stream from the multiplier
//   out_pix/out_sat/out_valid/out_ready : scaled pixel stream downstream
// Modports: master = the side that feeds products and consumes pixels,
//           slave  = the accumulator block itself.
// -----------------------------------------------------------------------------
interface interp_accum_if
  import pixelscale_pkg::*;
#(
  parameter int P_W = PROD_W,
  parameter int O_W = OUT_W_DEF
);

  logic [P_W-1:0] in_prod;
  logic           in_sop;
  logic           in_valid;
  logic           in_ready;
  logic [O_W-1:0] out_pix;
  logic           out_sat;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_prod, in_sop, in_valid, out_ready,
    input  in_ready, out_pix, out_sat, out_valid
  );

  modport slave (
    input  in_prod, in_sop, in_valid, out_ready,
    output in_ready, out_pix, out_sat, out_valid
  );

endinterface

// File: rtl/interp_round_sat.sv
// -----------------------------------------------------------------------------
// interp_round_sat
// Combinational fixed-point to pixel conversion: optional round-half-up,
// drop PRECISION fractional bits, clip to OUT_W bits.
//   acc_i : IN_W-bit unsigned fixed-point sum
//   pix_o : OUT_W-bit pixel (all ones when clipped)
//   sat_o : high when the value exceeded the pixel range
// Build option: INTERP_ACCUM_ROUND_EN adds 2^(PRECISION-1) before the shift;
// without it the shift truncates and no adder exists.
// -----------------------------------------------------------------------------
module interp_round_sat
  import pixelscale_pkg::*;
#(
  parameter int IN_W      = ACC_W,
  parameter int PRECISION = PRECISION_DEF,
  parameter int OUT_W     = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  acc_i,
  output logic [OUT_W-1:0] pix_o,
  output logic             sat_o
);

  localparam logic [IN_W-1:0] PIX_MAX = {{(IN_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [IN_W-1:0] shifted;

`ifdef INTERP_ACCUM_ROUND_EN
  // Callers size IN_W with headroom above the largest sum, so this add
  // cannot wrap.
  localparam logic [IN_W-1:0] HALF_LSB = IN_W'(1) << (PRECISION - 1);
  assign shifted = (acc_i + HALF_LSB) >> PRECISION;
`else
  assign shifted = acc_i >> PRECISION;
`endif

  assign sat_o = (shifted > PIX_MAX);
  assign pix_o = sat_o ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];

endmodule

// File: rtl/interp_accum.sv
// -----------------------------------------------------------------------------
// interp_accum
// Accumulates TAPS weighted products per output pixel, then rounds/truncates
// and saturates the sum to an OUT_W-bit pixel.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   bus       : interp_accum_if.slave (product in, pixel out, valid/ready)
//   err_align : sticky flag, set when a start-of-group arrives mid-group
// Build option: INTERP_ACCUM_ROUND_EN selects round-half-up instead of floor
// (handled inside interp_round_sat).
// -----------------------------------------------------------------------------
module interp_accum
  import pixelscale_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int R         = R_DEF,
  parameter int PRECISION = PRECISION_DEF,
  parameter int TAPS      = TAPS_DEF,
  parameter int OUT_W     = OUT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  interp_accum_if.slave   bus,
  output logic            err_align
);

  localparam int P_W   = PRECISION + N + R;
  localparam int A_W   = acc_width(P_W, TAPS);
  localparam int CNT_W = $clog2(TAPS);

  logic [A_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] tap_q, tap_d;
  logic [OUT_W-1:0] pix_q, pix_d;
  logic             sat_q, sat_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             last_tap;
  logic             accept;
  logic             realign;
  logic             final_acc;
  logic [A_W-1:0]   base;
  logic [A_W-1:0]   sum;
  logic [OUT_W-1:0] rs_pix;
  logic             rs_sat;

  assign last_tap = (tap_q == CNT_W'(TAPS - 1));

  // Only the final tap can be blocked, and only while the previous pixel is
  // still waiting; the same-cycle out_ready frees the slot for full throughput.
  assign bus.in_ready = !last_tap || !valid_q || bus.out_ready;

  assign accept    = bus.in_valid && bus.in_ready;
  // A start-of-group on any tap but the first restarts the group; it wins
  // over a final-tap completion so the stale partial sum is never emitted.
  assign realign   = accept && bus.in_sop && (tap_q != '0);
  assign final_acc = accept && last_tap && !realign;

  assign base = (tap_q == '0) ? '0 : acc_q;
  assign sum  = base + A_W'(bus.in_prod);

  interp_round_sat #(
    .IN_W      (A_W),
    .PRECISION (PRECISION),
    .OUT_W     (OUT_W)
  ) u_round_sat (
    .acc_i (sum),
    .pix_o (rs_pix),
    .sat_o (rs_sat)
  );

  // NOTE: every _d gets its hold value first, so no branch can leave one
  // unassigned and infer a latch.
  always_comb begin
    acc_d   = acc_q;
    tap_d   = tap_q;
    pix_d   = pix_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    err_d   = err_q;

    if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end

    if (realign) begin
      acc_d = A_W'(bus.in_prod);
      tap_d = CNT_W'(1);
      err_d = 1'b1;
    end else if (final_acc) begin
      acc_d   = '0;
      tap_d   = '0;
      pix_d   = rs_pix;
      sat_d   = rs_sat;
      valid_d = 1'b1;   // overrides a same-cycle drain: output reloads
    end else if (accept) begin
      acc_d = sum;
      tap_d = tap_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      tap_q   <= '0;
      pix_q   <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      pix_q   <= pix_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_pix   = pix_q;
  assign bus.out_sat   = sat_q;
  assign bus.out_valid = valid_q;
  assign err_align     = err_q;

endmodule
